// File: rtl/mbinit_pkg.sv
// Shared encodings for the MBINIT repair sequencer: FSM states, handshake
// phases and sideband message offsets relative to MSG_BASE.
package mbinit_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_BUSY  = 3'd1,
    SEND_REQ  = 3'd2,
    WAIT_RESP = 3'd3,
    PATTERN   = 3'd4,
    CHECK     = 3'd5,
    DONE      = 3'd6,
    ERROR     = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    PH_INIT   = 2'd0,
    PH_RESULT = 2'd1,
    PH_DONE   = 2'd2
  } phase_e;

  localparam logic [3:0] OFF_INIT_REQ    = 4'd0;
  localparam logic [3:0] OFF_INIT_RESP   = 4'd1;
  localparam logic [3:0] OFF_RESULT_REQ  = 4'd2;
  localparam logic [3:0] OFF_RESULT_RESP = 4'd3;
  localparam logic [3:0] OFF_DONE_REQ    = 4'd4;
  localparam logic [3:0] OFF_DONE_RESP   = 4'd5;

  function automatic logic [3:0] reqCode(input phase_e ph, input logic [3:0] base);
    case (ph)
      PH_INIT:   return base + OFF_INIT_REQ;
      PH_RESULT: return base + OFF_RESULT_REQ;
      default:   return base + OFF_DONE_REQ;
    endcase
  endfunction

  function automatic logic [3:0] respCode(input phase_e ph, input logic [3:0] base);
    case (ph)
      PH_INIT:   return base + OFF_INIT_RESP;
      PH_RESULT: return base + OFF_RESULT_RESP;
      default:   return base + OFF_DONE_RESP;
    endcase
  endfunction

endpackage

// File: rtl/mbinit_timeout_cnt.sv
// Per-wait cycle counter; expired is asserted while running once the count
// reaches TIMEOUT_CYC-1, and the count holds there until cleared.
module mbinit_timeout_cnt #(
  parameter int TIMEOUT_CYC = 8000
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run && (cnt_q != LastCnt)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = run && (cnt_q == LastCnt);

endmodule

// File: rtl/mbinit_repair_seq.sv
// MBINIT repair stage sequencer: init / pattern / result / done sideband handshake
// with bounded retries. Optional response timeout under MBINIT_REPAIR_TIMEOUT_EN.
module mbinit_repair_seq
  import mbinit_pkg::*;
#(
  parameter int         RESULT_W    = 3,
  parameter int         MAX_RETRY   = 2,
  parameter int         TIMEOUT_CYC = 8000,
  parameter logic [3:0] MSG_BASE    = 4'b0001
) (
  input  logic                           CLK,
  input  logic                           rst_n,
  input  logic                           i_enable,
  input  logic                           i_busy_sb,
  input  logic                           i_busy_fall,
  input  logic [3:0]                     i_rx_msg,
  input  logic                           i_rx_msg_valid,
  input  logic                           i_pattern_done,
  input  logic [RESULT_W-1:0]            i_result,
  output logic [3:0]                     o_tx_msg,
  output logic                           o_tx_valid,
  output logic                           o_pattern_en,
  output logic                           o_done,
  output logic                           o_train_error,
  output logic [$clog2(MAX_RETRY+1)-1:0] o_retry_cnt
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RetryMax = RW'(MAX_RETRY);

  state_e                state_q, state_d;
  phase_e                phase_q, phase_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [RESULT_W-1:0]   result_q, result_d;
  logic [3:0]            txMsg_q;
  logic                  txValid_q, patternEn_q, done_q, trainError_q;
  logic                  timeoutHit;

`ifdef MBINIT_REPAIR_TIMEOUT_EN
  logic toRun, toClear;

  assign toRun   = (state_q == WAIT_RESP) || (state_q == PATTERN);
  assign toClear = (state_d != state_q) && ((state_d == WAIT_RESP) || (state_d == PATTERN));

  mbinit_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .clear  (toClear),
    .run    (toRun),
    .expired(timeoutHit)
  );
`else
  assign timeoutHit = 1'b0;
`endif

  // Enable drop wins over everything, then timeout, then the normal handshake flow.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    retry_d  = retry_q;
    result_d = result_q;
    if (!i_enable) begin
      state_d = IDLE;
    end else if (timeoutHit) begin
      state_d = ERROR;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CHK_BUSY;
          phase_d = PH_INIT;
          retry_d = '0;
        end
        CHK_BUSY:  if (!i_busy_sb) state_d = SEND_REQ;
        SEND_REQ:  if (i_busy_fall) state_d = WAIT_RESP;
        WAIT_RESP: begin
          if (i_rx_msg_valid && (i_rx_msg == respCode(phase_q, MSG_BASE))) begin
            case (phase_q)
              PH_INIT:   state_d = PATTERN;
              PH_RESULT: begin
                result_d = i_result;
                state_d  = CHECK;
              end
              default:   state_d = DONE;
            endcase
          end
        end
        PATTERN: begin
          if (i_pattern_done) begin
            state_d = CHK_BUSY;
            phase_d = PH_RESULT;
          end
        end
        CHECK: begin
          if (&result_q) begin
            state_d = CHK_BUSY;
            phase_d = PH_DONE;
          end else if (retry_q < RetryMax) begin
            retry_d = retry_q + RW'(1);
            state_d = CHK_BUSY;
            phase_d = PH_INIT;
          end else begin
            state_d = ERROR;
          end
        end
        default: ;
      endcase
    end
    if (state_d == IDLE) begin
      retry_d = '0;
      phase_d = PH_INIT;
    end
  end

  // Outputs decode the next state so they line up with the state being entered.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= PH_INIT;
      retry_q      <= '0;
      result_q     <= '0;
      txMsg_q      <= 4'b0000;
      txValid_q    <= 1'b0;
      patternEn_q  <= 1'b0;
      done_q       <= 1'b0;
      trainError_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      retry_q      <= retry_d;
      result_q     <= result_d;
      txValid_q    <= (state_d == SEND_REQ);
      txMsg_q      <= (state_d == SEND_REQ) ? reqCode(phase_d, MSG_BASE) : 4'b0000;
      patternEn_q  <= (state_d == PATTERN);
      done_q       <= (state_d == DONE);
      trainError_q <= (state_d == ERROR);
    end
  end

  assign o_tx_msg      = txMsg_q;
  assign o_tx_valid    = txValid_q;
  assign o_pattern_en  = patternEn_q;
  assign o_done        = done_q;
  assign o_train_error = trainError_q;
  assign o_retry_cnt   = retry_q;

endmodule

// File: tb/tb_mbinit_repair_seq.sv
// Directed bench for mbinit_repair_seq: clean pass, retry, retry exhaustion,
// wrong message, abort, reset mid-handshake, and timeout when MBINIT_REPAIR_TIMEOUT_EN is set.
module tb_mbinit_repair_seq;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       i_enable, i_busy_sb, i_busy_fall, i_rx_msg_valid, i_pattern_done;
  logic [3:0] i_rx_msg;
  logic [2:0] i_result;
  logic [3:0] o_tx_msg;
  logic       o_tx_valid, o_pattern_en, o_done, o_train_error;
  logic [1:0] o_retry_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] txLog[$];

  always #5 CLK = ~CLK;

  mbinit_repair_seq #(
    .RESULT_W(3), .MAX_RETRY(2), .TIMEOUT_CYC(16), .MSG_BASE(4'b0001)
  ) dut (
    .CLK(CLK), .rst_n(rst_n), .i_enable(i_enable), .i_busy_sb(i_busy_sb),
    .i_busy_fall(i_busy_fall), .i_rx_msg(i_rx_msg), .i_rx_msg_valid(i_rx_msg_valid),
    .i_pattern_done(i_pattern_done), .i_result(i_result), .o_tx_msg(o_tx_msg),
    .o_tx_valid(o_tx_valid), .o_pattern_en(o_pattern_en), .o_done(o_done),
    .o_train_error(o_train_error), .o_retry_cnt(o_retry_cnt)
  );

  // A request counts as sent when the busy falling edge lands while it is offered.
  always @(posedge CLK) begin
    if (o_tx_valid && i_busy_fall) txLog.push_back(o_tx_msg);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  function automatic logic [31:0] packLog();
    logic [31:0] w = '0;
    foreach (txLog[i]) w = {w[27:0], txLog[i]};
    return w;
  endfunction

  task automatic waitTx(input logic [3:0] expReq);
    int n = 0;
    while (!o_tx_valid && n < 50) begin
      tick();
      n++;
    end
    checkOutput("txCode", o_tx_valid ? {28'd0, o_tx_msg} : 32'd0, {28'd0, expReq});
  endtask

  task automatic sendMsg(input logic [3:0] code, input logic [2:0] res);
    i_rx_msg = code;
    i_result = res;
    i_rx_msg_valid = 1'b1;
    tick();
    i_rx_msg_valid = 1'b0;
    i_rx_msg = 4'd0;
  endtask

  task automatic applyStimulus(input logic [3:0] expReq, input logic [3:0] resp, input logic [2:0] res);
    waitTx(expReq);
    i_busy_fall = 1'b1;
    tick();
    i_busy_fall = 1'b0;
    tick();
    sendMsg(resp, res);
  endtask

  task automatic runPattern(input bit finish);
    int n = 0;
    while (!o_pattern_en && n < 50) begin
      tick();
      n++;
    end
    checkOutput("patEn", {31'd0, o_pattern_en}, 32'd1);
    if (finish) begin
      i_pattern_done = 1'b1;
      tick();
      i_pattern_done = 1'b0;
    end
  endtask

  task automatic endStage();
    i_enable = 1'b0;
    repeat (2) tick();
    txLog.delete();
  endtask

  initial begin
    rst_n = 1'b0; i_enable = 1'b0; i_busy_sb = 1'b0; i_busy_fall = 1'b0;
    i_rx_msg = 4'd0; i_rx_msg_valid = 1'b0; i_pattern_done = 1'b0; i_result = 3'd0;
    repeat (3) tick();
    checkOutput("rstTxValid", {31'd0, o_tx_valid}, 32'd0);
    checkOutput("rstTxMsg", {28'd0, o_tx_msg}, 32'd0);
    checkOutput("rstPatEn", {31'd0, o_pattern_en}, 32'd0);
    checkOutput("rstDone", {31'd0, o_done}, 32'd0);
    checkOutput("rstErr", {31'd0, o_train_error}, 32'd0);
    checkOutput("rstRetry", {30'd0, o_retry_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Clean pass: requests 1, 3, 5
    i_enable = 1'b1;
    applyStimulus(4'd1, 4'd2, 3'b000);
    runPattern(1'b1);
    applyStimulus(4'd3, 4'd4, 3'b111);
    applyStimulus(4'd5, 4'd6, 3'b000);
    repeat (2) tick();
    checkOutput("cleanDone", {31'd0, o_done}, 32'd1);
    checkOutput("cleanRetry", {30'd0, o_retry_cnt}, 32'd0);
    checkOutput("cleanErr", {31'd0, o_train_error}, 32'd0);
    checkOutput("cleanLog", packLog(), 32'h135);
    repeat (3) tick();
    checkOutput("doneHeld", {31'd0, o_done}, 32'd1);
    i_enable = 1'b0;
    tick();
    checkOutput("doneClear", {31'd0, o_done}, 32'd0);
    endStage();

    // One failed result, then pass
    i_enable = 1'b1;
    applyStimulus(4'd1, 4'd2, 3'b000);
    runPattern(1'b1);
    applyStimulus(4'd3, 4'd4, 3'b101);
    applyStimulus(4'd1, 4'd2, 3'b000);
    runPattern(1'b1);
    applyStimulus(4'd3, 4'd4, 3'b111);
    applyStimulus(4'd5, 4'd6, 3'b000);
    repeat (2) tick();
    checkOutput("retryDone", {31'd0, o_done}, 32'd1);
    checkOutput("retryCnt", {30'd0, o_retry_cnt}, 32'd1);
    checkOutput("retryLog", packLog(), 32'h13135);
    endStage();

    // Retries exhausted
    i_enable = 1'b1;
    for (int r = 0; r < 3; r++) begin
      applyStimulus(4'd1, 4'd2, 3'b000);
      runPattern(1'b1);
      applyStimulus(4'd3, 4'd4, 3'b011);
    end
    repeat (3) tick();
    checkOutput("exhErr", {31'd0, o_train_error}, 32'd1);
    checkOutput("exhRetry", {30'd0, o_retry_cnt}, 32'd2);
    checkOutput("exhDone", {31'd0, o_done}, 32'd0);
    checkOutput("exhLog", packLog(), 32'h131313);
    checkOutput("exhTxValid", {31'd0, o_tx_valid}, 32'd0);
    endStage();

    // Wrong message in the result wait is ignored
    i_enable = 1'b1;
    applyStimulus(4'd1, 4'd2, 3'b000);
    runPattern(1'b1);
    applyStimulus(4'd3, 4'd2, 3'b000);
    repeat (3) tick();
    checkOutput("wrongTxValid", {31'd0, o_tx_valid}, 32'd0);
    checkOutput("wrongPatEn", {31'd0, o_pattern_en}, 32'd0);
    checkOutput("wrongRetry", {30'd0, o_retry_cnt}, 32'd0);
    sendMsg(4'd4, 3'b111);
    applyStimulus(4'd5, 4'd6, 3'b000);
    repeat (2) tick();
    checkOutput("wrongDone", {31'd0, o_done}, 32'd1);
    endStage();

    // Abort during pattern, then restart
    i_enable = 1'b1;
    applyStimulus(4'd1, 4'd2, 3'b000);
    runPattern(1'b0);
    i_enable = 1'b0;
    tick();
    checkOutput("abortPatEn", {31'd0, o_pattern_en}, 32'd0);
    checkOutput("abortTxValid", {31'd0, o_tx_valid}, 32'd0);
    tick();
    i_enable = 1'b1;
    waitTx(4'd1);
    endStage();

    // Reset mid-handshake leaves no residual request
    i_enable = 1'b1;
    waitTx(4'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstMidTxValid", {31'd0, o_tx_valid}, 32'd0);
    checkOutput("rstMidTxMsg", {28'd0, o_tx_msg}, 32'd0);
    i_enable = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("postRstTxValid", {31'd0, o_tx_valid}, 32'd0);
    txLog.delete();

`ifdef MBINIT_REPAIR_TIMEOUT_EN
    // No response after init_req: error 16 cycles after entering WAIT_RESP
    i_enable = 1'b1;
    waitTx(4'd1);
    i_busy_fall = 1'b1;
    tick();
    i_busy_fall = 1'b0;
    repeat (15) tick();
    checkOutput("toEarly", {31'd0, o_train_error}, 32'd0);
    tick();
    checkOutput("toErr", {31'd0, o_train_error}, 32'd1);
    endStage();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
